sc_matrix_row_scanner: RTL and testbench

//  Inverse of the row-combining OR stage: takes a full 8-row frame (fila7..fila0) and time-multiplexes it onto
//  an 8x8 LED matrix, one row per time slot. Outputs are a one-hot row strobe and that row's column bus.

---
 rtl/sc_matrix_row_scanner.sv | 153 +++++++++++++++
 tb/tb_sc_matrix_row_scanner.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sc_matrix_row_scanner.sv
// Row-multiplexing driver for an 8x8 LED matrix: scans a double-buffered 8-row frame
// one row per time slot, with blanking between rows and tear-free frame swaps.
module sc_matrix_row_scanner #(
  parameter int NUMBER_DATAWIDTH = 8,
  parameter int DWELL_CYCLES     = 50000,
  parameter int BLANK_CYCLES     = 4
) (
  input  logic                        SC_SCANNER_CLOCK_50,
  input  logic                        SC_SCANNER_RESET_InHigh,
  input  logic                        SC_SCANNER_enable_InHigh,
  input  logic                        SC_SCANNER_load_valid,
  output logic                        SC_SCANNER_load_ready,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_SCANNER_fila7_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_SCANNER_fila6_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_SCANNER_fila5_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_SCANNER_fila4_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_SCANNER_fila3_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_SCANNER_fila2_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_SCANNER_fila1_InBUS,
  input  logic [NUMBER_DATAWIDTH-1:0] SC_SCANNER_fila0_InBUS,
  output logic [7:0]                  SC_SCANNER_row_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0] SC_SCANNER_col_OutBUS,
  output logic                        SC_SCANNER_frame_done
);

  localparam int W       = NUMBER_DATAWIDTH;
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

  state_t         state, state_n;
  logic [2:0]     idx, idx_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [W-1:0]   active [8];
  logic [W-1:0]   active_n [8];
  logic [W-1:0]   shadow [8];
  logic [W-1:0]   fila [8];
  logic           pending, pending_n;
  logic           wrap;
  logic           accept;

  assign fila[0] = SC_SCANNER_fila0_InBUS;
  assign fila[1] = SC_SCANNER_fila1_InBUS;
  assign fila[2] = SC_SCANNER_fila2_InBUS;
  assign fila[3] = SC_SCANNER_fila3_InBUS;
  assign fila[4] = SC_SCANNER_fila4_InBUS;
  assign fila[5] = SC_SCANNER_fila5_InBUS;
  assign fila[6] = SC_SCANNER_fila6_InBUS;
  assign fila[7] = SC_SCANNER_fila7_InBUS;

  assign accept = SC_SCANNER_load_valid & SC_SCANNER_load_ready;

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    cnt_n     = cnt;
    active_n  = active;
    pending_n = pending;
    wrap      = 1'b0;
    // A load can only be accepted while nothing is pending, so it never collides with a promotion.
    if (accept) pending_n = 1'b1;
    case (state)
      IDLE: begin
        if (pending) begin
          active_n  = shadow;
          pending_n = 1'b0;
        end
        if (SC_SCANNER_enable_InHigh) begin
          state_n = SHOW;
          idx_n   = 3'd0;
          cnt_n   = '0;
        end
      end
      SHOW: begin
        if (!SC_SCANNER_enable_InHigh) begin
          state_n = IDLE;
          idx_n   = 3'd0;
          cnt_n   = '0;
        end else if (cnt == DWELL_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BLANK: begin
        if (!SC_SCANNER_enable_InHigh) begin
          state_n = IDLE;
          idx_n   = 3'd0;
          cnt_n   = '0;
        end else if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
            wrap = 1'b1;
            if (pending) begin
              active_n  = shadow;
              pending_n = 1'b0;
            end
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        idx_n   = 3'd0;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they are registered yet aligned with the state.
  always_ff @(posedge SC_SCANNER_CLOCK_50) begin
    if (SC_SCANNER_RESET_InHigh) begin
      state                 <= IDLE;
      idx                   <= 3'd0;
      cnt                   <= '0;
      pending               <= 1'b0;
      SC_SCANNER_load_ready <= 1'b1;
      SC_SCANNER_row_OutBUS <= 8'h00;
      SC_SCANNER_col_OutBUS <= '0;
      SC_SCANNER_frame_done <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        active[i] <= '0;
        shadow[i] <= '0;
      end
    end else begin
      state                 <= state_n;
      idx                   <= idx_n;
      cnt                   <= cnt_n;
      pending               <= pending_n;
      active                <= active_n;
      SC_SCANNER_load_ready <= ~pending_n;
      SC_SCANNER_frame_done <= wrap;
      if (accept) begin
        for (int i = 0; i < 8; i++) shadow[i] <= fila[i];
      end
      if (state_n == SHOW) begin
        SC_SCANNER_row_OutBUS <= 8'b1 << idx_n;
        SC_SCANNER_col_OutBUS <= active_n[idx_n];
      end else begin
        SC_SCANNER_row_OutBUS <= 8'h00;
        SC_SCANNER_col_OutBUS <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sc_matrix_row_scanner.sv
// Scoreboard bench for sc_matrix_row_scanner with DWELL=3, BLANK=1 (32-clock frame).
module tb_sc_matrix_row_scanner;

  logic       clk = 1'b0;
  logic       rst, en, vld;
  logic       rdy, fd;
  logic [7:0] row, col;
  logic [7:0] fila [8];

  always #5 clk = ~clk;

  sc_matrix_row_scanner #(
    .NUMBER_DATAWIDTH(8),
    .DWELL_CYCLES(3),
    .BLANK_CYCLES(1)
  ) dut (
    .SC_SCANNER_CLOCK_50(clk),
    .SC_SCANNER_RESET_InHigh(rst),
    .SC_SCANNER_enable_InHigh(en),
    .SC_SCANNER_load_valid(vld),
    .SC_SCANNER_load_ready(rdy),
    .SC_SCANNER_fila7_InBUS(fila[7]),
    .SC_SCANNER_fila6_InBUS(fila[6]),
    .SC_SCANNER_fila5_InBUS(fila[5]),
    .SC_SCANNER_fila4_InBUS(fila[4]),
    .SC_SCANNER_fila3_InBUS(fila[3]),
    .SC_SCANNER_fila2_InBUS(fila[2]),
    .SC_SCANNER_fila1_InBUS(fila[1]),
    .SC_SCANNER_fila0_InBUS(fila[0]),
    .SC_SCANNER_row_OutBUS(row),
    .SC_SCANNER_col_OutBUS(col),
    .SC_SCANNER_frame_done(fd)
  );

  typedef struct {
    int         cyc;
    int         tag;
    logic [7:0] row;
    logic [7:0] col;
    logic       rdy;
    logic       fd;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   tag     = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: pops every expectation due at this cycle and checks the output invariant.
  always @(negedge clk) begin
    if (cyc_cnt > 0) begin
      checks++;
      if (!(row == 8'h00 || $onehot(row)) || (row == 8'h00 && col != 8'h00)) begin
        errors++;
        $display("FAIL invariant cyc=%0d row=%h col=%h", cyc_cnt, row, col);
      end
    end
    while (q.size() > 0 && q[0].cyc <= cyc_cnt) begin
      e = q.pop_front();
      checks++;
      if (row !== e.row || col !== e.col || rdy !== e.rdy || fd !== e.fd) begin
        errors++;
        $display("FAIL step%0d cyc=%0d got row=%h col=%h rdy=%b fd=%b expected row=%h col=%h rdy=%b fd=%b",
                 e.tag, cyc_cnt, row, col, rdy, fd, e.row, e.col, e.rdy, e.fd);
      end
    end
  end

  logic [7:0] cur [8];
  int         pos;
  bit         started;

  task automatic step(input logic [7:0] r, input logic [7:0] c, input logic ry, input logic f);
    exp_t x;
    x.cyc = cyc_cnt + 1;
    x.tag = tag;
    x.row = r;
    x.col = c;
    x.rdy = ry;
    x.fd  = f;
    q.push_back(x);
    tag++;
    @(posedge clk);
    #1;
  endtask

  // Position p in a 32-clock frame: row p/4, shown for phases 0..2, blanked at phase 3.
  task automatic scan_step(input logic ry);
    logic [7:0] r, c;
    int ri;
    ri = pos / 4;
    if (pos % 4 < 3) begin
      r = 8'b1 << ri;
      c = cur[ri];
    end else begin
      r = 8'h00;
      c = 8'h00;
    end
    step(r, c, ry, (pos == 0) && started);
    started = 1'b1;
    pos = (pos + 1) % 32;
  endtask

  task automatic scan_n(input int n, input logic ry);
    for (int k = 0; k < n; k++) scan_step(ry);
  endtask

  task automatic set_fila(input logic [7:0] v);
    for (int i = 0; i < 8; i++) fila[i] = v;
  endtask

  initial begin
    // Reset held with enable and valid asserted
    rst = 1'b1; en = 1'b1; vld = 1'b1;
    set_fila(8'h55);
    step(8'h00, 8'h00, 1'b1, 1'b0);
    step(8'h00, 8'h00, 1'b1, 1'b0);
    rst = 1'b0; en = 1'b0; vld = 1'b0;
    step(8'h00, 8'h00, 1'b1, 1'b0);

    // Load in IDLE, then promotion on the following edge
    for (int i = 0; i < 8; i++) fila[i] = 8'b1 << i;
    vld = 1'b1;
    step(8'h00, 8'h00, 1'b0, 1'b0);
    vld = 1'b0;
    set_fila(8'h00);
    step(8'h00, 8'h00, 1'b1, 1'b0);

    // Full first frame, then a second frame starting with frame_done
    for (int i = 0; i < 8; i++) cur[i] = 8'b1 << i;
    en = 1'b1; pos = 0; started = 1'b0;
    scan_n(32, 1'b1);
    scan_n(13, 1'b1);

    // Mid-scan load in row 3 SHOW, then an ignored second valid while not ready
    set_fila(8'hFF); vld = 1'b1;
    scan_step(1'b0);
    set_fila(8'hAA);
    scan_step(1'b0);
    vld = 1'b0;
    set_fila(8'h00);
    scan_n(17, 1'b0);
    for (int i = 0; i < 8; i++) cur[i] = 8'hFF;
    scan_n(22, 1'b1);

    // Disable during row 5 SHOW, then restart from row 0
    en = 1'b0;
    step(8'h00, 8'h00, 1'b1, 1'b0);
    step(8'h00, 8'h00, 1'b1, 1'b0);
    en = 1'b1; pos = 0; started = 1'b0;
    scan_n(5, 1'b1);
    set_fila(8'h0F); vld = 1'b1;
    scan_step(1'b0);
    vld = 1'b0;
    set_fila(8'h00);
    scan_n(11, 1'b0);

    // Reset during row 4 with a pending frame; it must be discarded
    rst = 1'b1;
    step(8'h00, 8'h00, 1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cur[i] = 8'h00;
    pos = 0; started = 1'b0;
    scan_n(12, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expectations expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
